// File: rtl/program_loader_if.sv
// Host-stream and program-memory write bundle between the loader and its neighbours.
// The loader side uses the slave modport; the host/bench side uses master.
interface program_loader_if #(
   parameter int unsigned ADD_WIDTH  = 7,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  start;
   logic                  byte_valid;
   logic [DATA_WIDTH-1:0] byte_in;
   logic                  byte_ready;
   logic                  pmWrEn;
   logic [ADD_WIDTH-1:0]  pm_addr;
   logic [DATA_WIDTH-1:0] instructionIn;
   logic                  cpu_rst;
   logic                  done;
   logic                  error;

   modport master (
      output start, byte_valid, byte_in,
      input  byte_ready, pmWrEn, pm_addr, instructionIn, cpu_rst, done, error
   );

   modport slave (
      input  start, byte_valid, byte_in,
      output byte_ready, pmWrEn, pm_addr, instructionIn, cpu_rst, done, error
   );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into program memory and
// holds the CPU in reset until a verified image is present.
module program_loader #(
   parameter int unsigned ADD_WIDTH  = 7,
   parameter int unsigned DATA_WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   program_loader_if.slave  bus
);
   localparam int unsigned CNT_W = ADD_WIDTH + 1;
   localparam int unsigned CAP   = 32'(1) << ADD_WIDTH;

   localparam logic [2:0] S_HOLD = 3'd0;
   localparam logic [2:0] S_LEN  = 3'd1;
   localparam logic [2:0] S_LOAD = 3'd2;
   localparam logic [2:0] S_CHK  = 3'd3;
   localparam logic [2:0] S_RUN  = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   logic [2:0]            state_q, state_d;
   logic [CNT_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADD_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  ready_q, ready_d;
   logic                  cpu_rst_q, cpu_rst_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  accept;

   assign accept = bus.byte_valid && ready_q;

   // Next-state and registered-output logic; outputs follow the next state.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      wr_en_d = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      case (state_q)
         S_HOLD, S_RUN, S_ERR: begin
            if (bus.start) state_d = S_LEN;
         end
         S_LEN: begin
            if (accept) begin
               if (32'(bus.byte_in) > CAP) begin
                  state_d = S_ERR;
               end else begin
                  idx_d   = '0;
                  acc_d   = '0;
                  // A zero length byte stands for a full memory image.
                  cnt_d   = (bus.byte_in == '0) ? CNT_W'(CAP) : CNT_W'(bus.byte_in);
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               wr_en_d = 1'b1;
               addr_d  = idx_q[ADD_WIDTH-1:0];
               wdata_d = bus.byte_in;
               idx_d   = idx_q + CNT_W'(1);
               acc_d   = acc_q ^ bus.byte_in;
               if (idx_q + CNT_W'(1) == cnt_q) state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (accept) state_d = (acc_q == bus.byte_in) ? S_RUN : S_ERR;
         end
         default: state_d = S_HOLD;
      endcase

      ready_d   = (state_d == S_LEN) || (state_d == S_LOAD) || (state_d == S_CHK);
      cpu_rst_d = (state_d != S_RUN);
      done_d    = (state_d == S_RUN);
      error_d   = (state_d == S_ERR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_HOLD;
         idx_q     <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         wr_en_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         ready_q   <= 1'b0;
         cpu_rst_q <= 1'b1;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         wr_en_q   <= wr_en_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ready_q   <= ready_d;
         cpu_rst_q <= cpu_rst_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign bus.byte_ready    = ready_q;
   assign bus.pmWrEn        = wr_en_q;
   assign bus.pm_addr       = addr_q;
   assign bus.instructionIn = wdata_q;
   assign bus.cpu_rst       = cpu_rst_q;
   assign bus.done          = done_q;
   assign bus.error         = error_q;
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued as bytes
// are driven and matched against every observed pmWrEn pulse.
module tb_program_loader;
   localparam int unsigned AW = 7;
   localparam int unsigned DW = 8;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   program_loader_if #(.ADD_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   program_loader #(.ADD_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int  checks   = 0;
   int  errors   = 0;
   int  wr_count = 0;
   wr_t sb_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every pulse must match the oldest outstanding expected write.
   always @(negedge clk) begin : mon
      wr_t e;
      if (bus.pmWrEn === 1'b1) begin
         wr_count++;
         if (sb_q.size() == 0) begin
            check_eq("unexpected_wr", 32'({bus.pm_addr, bus.instructionIn}), 32'hFFFF_FFFF);
         end else begin
            e = sb_q.pop_front();
            check_eq("wr_addr", 32'(bus.pm_addr), 32'(e.addr));
            check_eq("wr_data", 32'(bus.instructionIn), 32'(e.data));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit rnd);
      bit ok = 1'b0;
      int n  = 0;
      while (!ok && n < 400) begin
         @(negedge clk);
         bus.byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.byte_in    = b;
         if (bus.byte_valid && bus.byte_ready) ok = 1'b1;
         n++;
      end
      if (!ok) check_eq("send_timeout", 32'(ok), 32'd1);
   endtask

   task automatic do_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check_eq("start_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      check_eq("start_done", 32'(bus.done), 32'd0);
      check_eq("start_ready", 32'(bus.byte_ready), 32'd1);
   endtask

   task automatic run_load(input logic [7:0] len, input logic [7:0] data[$],
                           input logic [7:0] csum, input bit rnd);
      int         w0 = wr_count;
      logic [7:0] x  = 8'h00;
      bit         exp_ok;
      send_byte(len, rnd);
      for (int i = 0; i < data.size(); i++) begin
         x = x ^ data[i];
         sb_q.push_back('{addr: AW'(i), data: data[i]});
         send_byte(data[i], rnd);
      end
      check_eq("pre_chk_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      send_byte(csum, rnd);
      @(negedge clk);
      bus.byte_valid = 1'b0;
      exp_ok = (x == csum);
      check_eq("end_done", 32'(bus.done), 32'(exp_ok));
      check_eq("end_error", 32'(bus.error), 32'(!exp_ok));
      check_eq("end_cpu_rst", 32'(bus.cpu_rst), 32'(!exp_ok));
      check_eq("end_ready", 32'(bus.byte_ready), 32'd0);
      check_eq("wr_total", 32'(wr_count - w0), 32'(data.size()));
   endtask

   initial begin
      logic [7:0] d[$];
      int         w0;
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_in    = '0;
      #12;
      check_eq("rst_pmWrEn", 32'(bus.pmWrEn), 32'd0);
      check_eq("rst_pm_addr", 32'(bus.pm_addr), 32'd0);
      check_eq("rst_instr", 32'(bus.instructionIn), 32'd0);
      check_eq("rst_ready", 32'(bus.byte_ready), 32'd0);
      check_eq("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_error", 32'(bus.error), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Byte offered in HOLD without start must be ignored.
      bus.byte_valid = 1'b1;
      bus.byte_in    = 8'h04;
      @(negedge clk);
      check_eq("hold_ready", 32'(bus.byte_ready), 32'd0);
      bus.byte_valid = 1'b0;

      d = '{8'h13, 8'h05, 8'h10, 8'h00};
      do_start();
      run_load(8'h04, d, 8'h06, 1'b0);

      do_start();
      run_load(8'h04, d, 8'h07, 1'b0);

      d.delete();
      for (int i = 0; i < 128; i++) d.push_back(8'(i));
      do_start();
      run_load(8'h00, d, 8'h00, 1'b0);

      w0 = wr_count;
      do_start();
      send_byte(8'h81, 1'b0);
      @(negedge clk);
      bus.byte_valid = 1'b0;
      check_eq("len81_error", 32'(bus.error), 32'd1);
      check_eq("len81_ready", 32'(bus.byte_ready), 32'd0);
      check_eq("len81_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      @(negedge clk);
      check_eq("len81_no_wr", 32'(wr_count - w0), 32'd0);

      d = '{8'hAA, 8'h55};
      do_start();
      run_load(8'h02, d, 8'hFF, 1'b1);

      // Reset mid-load after two of four data bytes.
      do_start();
      send_byte(8'h04, 1'b0);
      sb_q.push_back('{addr: AW'(0), data: 8'h21});
      send_byte(8'h21, 1'b0);
      sb_q.push_back('{addr: AW'(1), data: 8'h42});
      send_byte(8'h42, 1'b0);
      @(negedge clk);
      bus.byte_in = 8'h63;
      check_eq("pre_rst_pmWrEn", 32'(bus.pmWrEn), 32'd1);
      #1 rst = 1'b1;
      #1;
      check_eq("mid_rst_pmWrEn", 32'(bus.pmWrEn), 32'd0);
      check_eq("mid_rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      check_eq("mid_rst_ready", 32'(bus.byte_ready), 32'd0);
      bus.byte_valid = 1'b0;
      #1 rst = 1'b0;

      d = '{8'h01, 8'h02, 8'h04, 8'h08};
      do_start();
      run_load(8'h04, d, 8'h0F, 1'b0);

      repeat (3) @(negedge clk);
      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that drives the CPU's program-memory write port (`pmWrEn`, `pm_addr`, `instructionIn`) and holds the CPU in reset until a checksum-verified image is in memory. It accepts a length-prefixed, XOR-checksummed byte stream over a valid/ready handshake and writes bytes to sequential program-memory addresses starting at 0. It sits between the external host link and `pipelined_risc_v_cpu`: it owns the CPU `rst` input and the program-memory write inputs.

## Interface
- `ADD_WIDTH`, 7: program-memory address width; capacity `2^ADD_WIDTH` bytes.
- `DATA_WIDTH`, 8: byte width of the stream and of the memory write data.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a (re)load.
- `byte_valid`  in  1  host presents `byte_in`.
- `byte_in`  in  DATA_WIDTH  stream byte.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `pmWrEn`  out  1  program-memory write enable; one-cycle pulse per data byte.
- `pm_addr`  out  ADD_WIDTH  program-memory write address.
- `instructionIn`  out  DATA_WIDTH  program-memory write data.
- `cpu_rst`  out  1  reset to the CPU; high whenever the loader is not in RUN.
- `done`  out  1  high in RUN.
- `error`  out  1  high in ERR.

## Operation
- Transfer: a byte is accepted on a rising edge where `byte_valid && byte_ready`. Bytes presented while `byte_ready` is low are ignored and are not consumed.
- Stream format: length byte L, then N data bytes, then one checksum byte.
  - N = L for 1 ≤ L ≤ 2^ADD_WIDTH; L = 0 means N = 2^ADD_WIDTH.
  - The checksum is the XOR of all N data bytes.
- States:
  - HOLD: reset state, waiting for `start`.
  - LEN: `byte_ready` = 1. Accept L. If L > 2^ADD_WIDTH, go to ERR; otherwise clear the index and the XOR accumulator and go to LOAD.
  - LOAD: `byte_ready` = 1. Each accepted byte is written at address = index, then the index increments and the accumulator XORs in the byte. After the N-th byte, go to CHK.
  - CHK: `byte_ready` = 1. Accept the checksum byte. On match go to RUN; on mismatch go to ERR.
  - RUN: `done` = 1, `cpu_rst` = 0.
  - ERR: `error` = 1, `cpu_rst` = 1.
- `start` is honoured only in HOLD, RUN and ERR, and moves the FSM to LEN. In LEN, LOAD and CHK, `start` is ignored.
- `byte_ready` = 0 in HOLD, RUN and ERR.
- Index width is ADD_WIDTH+1 so that the N = 2^ADD_WIDTH case terminates. `pm_addr` takes the low ADD_WIDTH bits, so the last address is 2^ADD_WIDTH−1 and no wrap-around write ever occurs.
- Memory contents outside addresses 0..N−1 are not touched.

## Timing
- Reset values: state HOLD, `pmWrEn` 0, `pm_addr` 0, `instructionIn` 0, `byte_ready` 0, `cpu_rst` 1, `done` 0, `error` 0, index 0, accumulator 0.
- Outputs are registered:
  - For a data byte accepted at edge k, `pmWrEn` = 1 with the matching `pm_addr`/`instructionIn` during cycle k..k+1, and memory captures it at edge k+1.
  - `pmWrEn` falls the following cycle unless another byte was accepted at edge k+1.
  - Back-to-back acceptance gives one write per cycle.
- Throughput: one byte per cycle with `byte_valid` held high. A complete load takes N+2 accepting cycles.
- `cpu_rst` falls the cycle after the matching checksum is accepted. `done` rises in the same cycle.
- `start` in RUN: `cpu_rst` rises and `done` falls the cycle after the `start` edge.
- Asynchronous `rst` mid-load: the FSM returns to HOLD and `pmWrEn` drops immediately, with no partial write after reset. Memory keeps the bytes already written.
- Simultaneous `start` and `byte_valid` in HOLD/RUN/ERR: the byte is not accepted because `byte_ready` = 0 there.

## Test plan
- Reset, `start`, stream 0x04, 0x13, 0x05, 0x10, 0x00, checksum 0x06 at one byte per cycle:
  - writes (0,0x13), (1,0x05), (2,0x10), (3,0x00) on consecutive cycles;
  - `done` = 1 and `cpu_rst` = 0 one cycle after the checksum is accepted.
- Same stream with checksum 0x07: four writes occur; `error` = 1; `cpu_rst` stays 1.
- Length 0x00 with 128 bytes of value i, then checksum 0x00:
  - writes to addresses 0..127 only, with no write at address 0 after 127;
  - `done` = 1.
- Length 0x81 → ERR immediately, with no `pmWrEn` pulse.
- `byte_valid` toggled randomly during load of 0x02, 0xAA, 0x55, 0xFF: exactly two writes, (0,0xAA) and (1,0x55); `done` = 1.
- `rst` asserted after 2 of 4 data bytes: immediate HOLD, `pmWrEn` = 0, `cpu_rst` = 1. A subsequent `start` plus a full stream reloads correctly.
